// File: rtl/display_pkg.sv
// Shared types, glyph constants and helpers for the multiplexed 7-segment display.
// Segment vectors are active-high internally, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_OFF  = 7'b000_0000;
  localparam logic [6:0] SEG_DASH = 7'b100_0000;

  localparam logic [6:0] SEG_GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Codes 10-15 cannot come out of a correct conversion; they render dark.
  function automatic logic [6:0] seg_encode(input bcd_digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_GLYPH[0];
      4'd1:    seg = SEG_GLYPH[1];
      4'd2:    seg = SEG_GLYPH[2];
      4'd3:    seg = SEG_GLYPH[3];
      4'd4:    seg = SEG_GLYPH[4];
      4'd5:    seg = SEG_GLYPH[5];
      4'd6:    seg = SEG_GLYPH[6];
      4'd7:    seg = SEG_GLYPH[7];
      4'd8:    seg = SEG_GLYPH[8];
      4'd9:    seg = SEG_GLYPH[9];
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  function automatic int max1(input int x);
    return (x < 1) ? 1 : x;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, IN_WIDTH cycles per value.
// done and bcd are valid together in the final busy cycle so the caller can latch atomically.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_WIDTH-1:0]           value,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output bcd_digit_t [N_DIGITS-1:0]     bcd
);

  localparam int               CNT_W    = $clog2(IN_WIDTH + 1);
  localparam logic [31:0]      MAX_VAL  = pow10(N_DIGITS) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [IN_WIDTH-1:0]       shift_r;
  bcd_digit_t [N_DIGITS-1:0] work_r;
  bcd_digit_t [N_DIGITS-1:0] adj_s;
  bcd_digit_t [N_DIGITS-1:0] work_next_s;
  logic [4*N_DIGITS:0]       cat_s;
  logic [CNT_W-1:0]          cnt_r;
  logic                      busy_r;
  logic                      ovf_pend_r;

  // Add-3 correction on every digit, then shift in the next binary MSB.
  // Digits above N_DIGITS fall off the top; overflow is judged on the binary value instead.
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (work_r[i] >= 4'd5) begin
        adj_s[i] = work_r[i] + 4'd3;
      end else begin
        adj_s[i] = work_r[i];
      end
    end
    cat_s       = {adj_s, shift_r[IN_WIDTH-1]};
    work_next_s = cat_s[4*N_DIGITS-1:0];
  end

  // Capture on start when idle, then step once per cycle until the count expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= '0;
      work_r     <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      ovf_pend_r <= 1'b0;
    end else if (!busy_r) begin
      if (start) begin
        shift_r    <= value;
        work_r     <= '0;
        cnt_r      <= CNT_LOAD;
        busy_r     <= 1'b1;
        ovf_pend_r <= (32'(value) > MAX_VAL);
      end
    end else begin
      shift_r <= shift_r << 1'b1;
      work_r  <= work_next_s;
      cnt_r   <= cnt_r - CNT_ONE;
      if (cnt_r == CNT_ONE) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = busy_r && (cnt_r == CNT_ONE);
  assign overflow = ovf_pend_r;
  assign bcd      = work_next_s;

endmodule

// File: rtl/display_7seg_scan_ctrl.sv
// Binary-to-7-segment multiplexed display controller with leading-zero blanking,
// overflow dashes and whole-display blink.
module display_7seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int IN_WIDTH       = 14,
  parameter int CLK_HZ         = 200_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [IN_WIDTH-1:0] i_value,
  input  logic                i_load,
  input  logic                i_blank_lz,
  input  logic                i_blink_en,
  output logic                o_busy,
  output logic                o_overflow,
  output logic [6:0]          o_seg,
  output logic [N_DIGITS-1:0] o_disp_sel
);

  localparam int SLOT_CYCLES = max1(CLK_HZ / (SCAN_HZ * N_DIGITS));
  localparam int BLINK_HALF  = max1(CLK_HZ / (2 * BLINK_HZ));
  localparam int SLOT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BLINK_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IDX_W       = $clog2(N_DIGITS);

  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]   SLOT_ONE   = SLOT_W'(1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0]  BLINK_ONE  = BLINK_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
  localparam logic [6:0]          SEG_XOR    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] SEL_XOR    = (SEL_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic                      conv_busy_s;
  logic                      conv_done_s;
  logic                      conv_ovf_s;
  bcd_digit_t [N_DIGITS-1:0] conv_bcd_s;

  bcd_digit_t [N_DIGITS-1:0] digits_r;
  logic                      ovf_r;
  logic [SLOT_W-1:0]         slot_cnt_r;
  logic [IDX_W-1:0]          idx_r;
  logic [BLINK_W-1:0]        blink_cnt_r;
  logic                      blink_on_r;

  logic [N_DIGITS-1:0]       lead_nz_s;
  bcd_digit_t                cur_digit_s;
  logic                      blank_s;
  logic [6:0]                seg_s;
  logic [N_DIGITS-1:0]       sel_s;

  bin2bcd_seq #(
    .IN_WIDTH (IN_WIDTH),
    .N_DIGITS (N_DIGITS)
  ) u_conv (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .start    (i_load),
    .value    (i_value),
    .busy     (conv_busy_s),
    .done     (conv_done_s),
    .overflow (conv_ovf_s),
    .bcd      (conv_bcd_s)
  );

  // Displayed digits and overflow change together, only on the conversion's last step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      digits_r <= '0;
      ovf_r    <= 1'b0;
    end else if (conv_done_s) begin
      digits_r <= conv_bcd_s;
      ovf_r    <= conv_ovf_s;
    end
  end

  // Slot timer and scan index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_cnt_r <= '0;
      idx_r      <= '0;
    end else if (slot_cnt_r == SLOT_LAST) begin
      slot_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_ONE;
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_ONE;
    end
  end

  // Blink phase; held in the on phase whenever blinking is disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else if (!i_blink_en) begin
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      blink_on_r  <= !blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_ONE;
    end
  end

  // lead_nz_s[k] is set when digit k or any more significant digit is non-zero.
  always_comb begin
    lead_nz_s = '0;
    lead_nz_s[N_DIGITS-1] = (digits_r[N_DIGITS-1] != 4'd0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      lead_nz_s[k] = lead_nz_s[k+1] | (digits_r[k] != 4'd0);
    end
  end

  // Glyph and select for the digit currently being scanned.
  always_comb begin
    cur_digit_s = digits_r[idx_r];
    blank_s     = i_blank_lz && (idx_r != '0) && !lead_nz_s[idx_r];
    sel_s       = '0;
    if (ovf_r) begin
      seg_s = SEG_DASH;
    end else if (blank_s) begin
      seg_s = SEG_OFF;
    end else begin
      seg_s = seg_encode(cur_digit_s);
    end
    if (blink_on_r) begin
      sel_s[idx_r] = 1'b1;
    end else begin
      sel_s = '0;
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg      <= SEG_OFF ^ SEG_XOR;
      o_disp_sel <= SEL_XOR;
    end else begin
      o_seg      <= seg_s ^ SEG_XOR;
      o_disp_sel <= sel_s ^ SEL_XOR;
    end
  end

  assign o_busy     = conv_busy_s;
  assign o_overflow = ovf_r;

endmodule

// File: tb/tb_display_7seg_scan_ctrl.sv
// Scoreboard bench: a posedge model predicts busy, scan slot and blink phase from
// elapsed cycles; a negedge monitor compares the DUT and retires queued loads.
module tb_display_7seg_scan_ctrl;

  localparam int N_DIG       = 4;
  localparam int W           = 14;
  localparam int BUSY_CYCLES = 14;
  localparam int SLOT        = 2;
  localparam int HALF        = 8;
  localparam int MAX_DISP    = 9999;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i_value;
  logic         i_load;
  logic         i_blank_lz;
  logic         i_blink_en;
  logic         o_busy;
  logic         o_overflow;
  logic [6:0]   o_seg;
  logic [3:0]   o_disp_sel;

  always #5 clk = ~clk;

  display_7seg_scan_ctrl #(
    .N_DIGITS       (N_DIG),
    .IN_WIDTH       (W),
    .CLK_HZ         (8000),
    .SCAN_HZ        (1000),
    .BLINK_HZ       (500),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_blank_lz (i_blank_lz),
    .i_blink_en (i_blink_en),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_seg      (o_seg),
    .o_disp_sel (o_disp_sel)
  );

  int checks = 0;
  int failures = 0;

  // Standard glyphs {g,f,e,d,c,b,a}, active high.
  logic [6:0] glyph_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int  exp_q[$];
  int  left = 0;
  int  cyc = 0;
  int  blink_e = 0;
  int  snap_digit = 0;
  bit  snap_off = 1'b0;
  bit  snap_blank = 1'b0;
  bit  snap_busy = 1'b0;
  bit  snap_valid = 1'b0;
  int  cur_value = 0;
  bit  prev_busy = 1'b0;
  logic [3:0] act_sel;
  logic [6:0] act_seg;

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_glyph(input int v, input int k, input bit bl);
    if (v > MAX_DISP) return 7'h40;
    if (bl && k > 0 && v < pow10(k)) return 7'h00;
    return glyph_tbl[(v / pow10(k)) % 10];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state that exists just before each rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      cyc        = 0;
      blink_e    = 0;
      left       = 0;
      snap_valid = 1'b0;
    end else begin
      snap_digit = (cyc / SLOT) % N_DIG;
      cyc++;
      snap_off   = ((blink_e / HALF) % 2) == 1;
      blink_e    = i_blink_en ? blink_e + 1 : 0;
      snap_blank = i_blank_lz;
      if (left > 0) left--;
      else if (i_load) begin
        exp_q.push_back(int'(i_value));
        left = BUSY_CYCLES;
      end
      snap_busy  = (left > 0);
      snap_valid = 1'b1;
    end
  end

  // Monitor on the falling edge, away from DUT register updates.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_sel", o_disp_sel, 4'hF);
      check("rst_seg", o_seg, 7'h7F);
      check("rst_busy", o_busy, 0);
      check("rst_ovf", o_overflow, 0);
      exp_q.delete();
      cur_value = 0;
      prev_busy = 1'b0;
    end else if (snap_valid) begin
      int next_value;
      next_value = cur_value;
      check("busy", o_busy, snap_busy);
      if (prev_busy && !o_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_without_load: busy fell with empty queue at %0t", $time);
        end else begin
          next_value = exp_q.pop_front();
        end
      end
      check("overflow", o_overflow, next_value > MAX_DISP);
      act_sel = ~o_disp_sel;
      act_seg = ~o_seg;
      if (snap_off) begin
        check("blink_off_sel", act_sel, 0);
      end else begin
        check("scan_sel", act_sel, 1 << snap_digit);
        check("scan_seg", act_seg, exp_glyph(cur_value, snap_digit, snap_blank));
      end
      cur_value = next_value;
      prev_busy = o_busy;
    end
  end

  task automatic load(input int v);
    @(negedge clk);
    i_value = W'(v);
    i_load  = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_value    = '0;
    i_load     = 1'b0;
    i_blank_lz = 1'b0;
    i_blink_en = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(10);

    load(1234);  idle(24);
    i_blank_lz = 1'b1;
    load(7);     idle(24);
    i_blank_lz = 1'b0;
    idle(10);
    load(12000); idle(24);
    load(9999);  idle(24);
    load(42);    idle(3);
    load(99);    idle(24);

    i_blink_en = 1'b1; idle(40);
    i_blink_en = 1'b0; idle(12);

    load(5555);  idle(6);
    #2 rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(12);
    i_blank_lz = 1'b1;
    idle(10);

    repeat (24) begin
      i_blank_lz = 1'($urandom_range(0, 1));
      load($urandom_range(0, 16383));
      idle($urandom_range(0, 20));
    end
    i_blink_en = 1'b1; idle(30);
    i_blink_en = 1'b0; idle(30);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_loads: got %0d queued expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_7seg_scan_ctrl.md
DISPLAY_7SEG_SCAN_CTRL -- requirements
Module: display_7seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter IN_WIDTH, default 14, binary input width (1..27).
REQ-003 SHALL have parameter CLK_HZ, default 200_000_000, i_clk frequency.
REQ-004 SHALL have parameter SCAN_HZ, default 1000, full-frame refresh rate.
REQ-005 SHALL have parameter BLINK_HZ, default 2, blink toggle-pair rate.
REQ-006 SHALL have parameter SEG_ACTIVE_LOW, default 1, segment polarity.
REQ-007 SHALL have parameter SEL_ACTIVE_LOW, default 1, digit-select polarity.
REQ-008 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port i_value  input  IN_WIDTH  unsigned binary value to display.
REQ-011 SHALL have port i_load  input  1  single-cycle capture strobe for i_value.
REQ-012 SHALL have port i_blank_lz  input  1  leading-zero blanking enable.
REQ-013 SHALL have port i_blink_en  input  1  whole-display blink enable.
REQ-014 SHALL have port o_busy  output  1  conversion in progress.
REQ-015 SHALL have port o_overflow  output  1  displayed value exceeds 10^N_DIGITS-1.
REQ-016 SHALL have port o_seg  output  7  segments {g,f,e,d,c,b,a}, a = bit 0.
REQ-017 SHALL have port o_disp_sel  output  N_DIGITS  one-hot digit select, bit 0 = units.

Function
REQ-018 SHALL, on i_load high while o_busy low, capture i_value and assert o_busy the next cycle.
REQ-019 SHALL ignore i_load while o_busy high; no queuing.
REQ-020 SHALL convert with sequential shift-add-3 (double dabble), one shift per cycle, exactly IN_WIDTH cycles, o_busy high for those cycles.
REQ-021 SHALL update all displayed digits and o_overflow atomically in the cycle o_busy falls; the display never shows a partial result.
REQ-022 SHALL set o_overflow when captured value > 10^N_DIGITS-1 and then show segment g only ("-") on every digit.
REQ-023 SHALL advance the scan index every CLK_HZ/(SCAN_HZ*N_DIGITS) cycles (minimum 1), wrapping N_DIGITS-1 -> 0.
REQ-024 SHALL drive exactly one o_disp_sel bit active and o_seg for that digit, both registered, changing in the same cycle.
REQ-025 SHALL, with i_blank_lz high, blank every zero digit more significant than the most significant non-zero digit; the units digit is never blanked.
REQ-026 SHALL, with i_blink_en high, toggle a blink phase every CLK_HZ/(2*BLINK_HZ) cycles; in the off phase all o_disp_sel bits inactive, scanning continues.
REQ-027 SHALL reset the blink phase to on when i_blink_en falls.
REQ-028 SHALL encode digits 0-9 per standard 7-segment glyphs; BCD codes 10-15 never displayed (off).
REQ-029 SHALL apply SEG_ACTIVE_LOW / SEL_ACTIVE_LOW inversion only at the output registers.

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously clear: scan index 0, all digits 0, o_busy 0, o_overflow 0, blink phase on, counters 0.
REQ-031 SHALL, in reset, drive o_disp_sel all inactive and o_seg all off.
REQ-032 SHALL, first scan slot after reset release, select digit 0 showing "0".
REQ-033 SHALL abandon an in-flight conversion on reset; displayed value returns to 0.

Structure
REQ-034 SHALL place segment glyph table, SEG_OFF, SEG_DASH constants and BCD digit typedef in package display_pkg.
REQ-035 SHALL implement conversion in sub-module bin2bcd_seq (start/busy/done, parametrised IN_WIDTH and N_DIGITS).

Verification
(Bench params: CLK_HZ=8000, SCAN_HZ=1000, N_DIGITS=4, IN_WIDTH=14, BLINK_HZ=500 -> 2-cycle slot, 8-cycle blink half-period.)
REQ-036 SHALL verify load 1234 -> o_busy high 14 cycles, then digits 3..0 scan as 1,2,3,4 with slot length 2 cycles.
REQ-037 SHALL verify load 7 with i_blank_lz=1 -> digits 3..1 blank, digit 0 shows 7; with i_blank_lz=0 -> "0007".
REQ-038 SHALL verify load 12000 -> o_overflow=1, all four digits show "-"; then load 9999 -> o_overflow=0, "9999".
REQ-039 SHALL verify load 42 then second i_load of 99 during busy -> display 42, second load ignored.
REQ-040 SHALL verify i_blink_en=1 -> o_disp_sel inactive for alternate 8-cycle windows, scan index keeps advancing.
REQ-041 SHALL verify i_rst_n low mid-conversion of 5555 -> outputs off immediately; after release display "0", o_busy=0.
